if_id_queue: RTL

//   Parametrised IF->ID boundary: DEPTH-entry instruction queue with valid/ready on both sides, replacing
//   the single IF/ID register. Decouples fetch from decode stalls, supports flush on redirect, and presents
//   a NOP bubble plus decoded register addresses (rs1/rs2/rd) to ID. Sits between fetch and decode/regfile.

---
 rtl/if_id_queue.sv | 117 +++++++++++
 1 files changed

// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//   DEPTH-entry FIFO on the IF->ID boundary. Fetch pushes {pc, instr} with
//   valid/ready; decode pops the head with valid/ready. The head is shown
//   first-word-fall-through from registered storage. When the queue is empty,
//   the head is masked to pc=0 / instr=NOP. A flush (redirect) empties the
//   queue in one edge.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   if_valid / if_ready   fetch handshake; if_ready = ~full (registered)
//   if_pc, if_instr       fetched PC / instruction
//   flush                 drop every entry, including same-cycle push/pop
//   id_ready / id_valid   decode handshake; id_valid = ~empty
//   id_pc, id_instr       head entry (0 / NOP when empty)
//   rs1_raddr, rs2_raddr  register-file read addresses sliced from id_instr
//   rd_waddr              destination register sliced from id_instr
//   count                 number of entries held
// ---------------------------------------------------------------------------
module if_id_queue #(
    parameter int                 PC_W    = 32,
    parameter int                 INSTR_W = 32,
    parameter int                 DEPTH   = 2,   // power of two, >= 2
    parameter logic [INSTR_W-1:0] NOP     = INSTR_W'(32'h0000_0013)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         if_valid,
    output logic                         if_ready,
    input  logic [PC_W-1:0]              if_pc,
    input  logic [INSTR_W-1:0]           if_instr,
    input  logic                         flush,
    input  logic                         id_ready,
    output logic                         id_valid,
    output logic [PC_W-1:0]              id_pc,
    output logic [INSTR_W-1:0]           id_instr,
    output logic [4:0]                   rs1_raddr,
    output logic [4:0]                   rs2_raddr,
    output logic [4:0]                   rd_waddr,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    logic               empty, full, push, pop;
    entry_t             head;

    // Both handshakes depend only on registered count. A pop in the same
    // cycle never opens a slot for a push, so there is no id_ready->if_ready path.
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign if_ready = ~full;
    assign id_valid = ~empty;

    assign push = if_valid & if_ready & ~flush;
    assign pop  = id_valid & id_ready & ~flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: if_pc, instr: if_instr};
                // DEPTH is a power of two, so the pointer wraps by overflow.
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage is not reset. Stale contents are hidden by the empty mask.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign id_pc     = empty ? '0  : head.pc;
    assign id_instr  = empty ? NOP : head.instr;
    assign rs1_raddr = id_instr[19:15];
    assign rs2_raddr = id_instr[24:20];
    assign rd_waddr  = id_instr[11:7];
    assign count     = count_q;

endmodule
